seg_display_scanner: RTL and testbench

SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

---
 rtl/seg_display_pkg.sv | 25 ++
 rtl/hex_7seg_decoder.sv | 32 +++
 rtl/seg_display_scanner.sv | 104 ++++++++++
 tb/tb_seg_display_scanner.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared constants, types and helpers for the four-digit seven-segment scanner.
package seg_display_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // Bit k set when digits k..3 are all zero; digit 0 is never blanked.
    function automatic logic [NUM_DIGITS-1:0] lz_blank_mask(
        input logic [NUM_DIGITS*DIGIT_W-1:0] value
    );
        logic [NUM_DIGITS-1:0] mask;
        logic                  upper_zero;
        mask       = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (value[k*DIGIT_W +: DIGIT_W] == '0);
            mask[k]    = upper_zero;
        end
        return mask;
    endfunction

endpackage

// File: rtl/hex_7seg_decoder.sv
// Combinational hex nibble to {a,b,c,d,e,f,g} segment pattern, active-high.
module hex_7seg_decoder
    import seg_display_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_nibble,
    output logic [6:0]         o_seg
);

    always_comb begin
        o_seg = 7'b0000000;
        case (i_nibble)
            4'h0: o_seg = 7'b1111110;
            4'h1: o_seg = 7'b0110000;
            4'h2: o_seg = 7'b1101101;
            4'h3: o_seg = 7'b1111001;
            4'h4: o_seg = 7'b0110011;
            4'h5: o_seg = 7'b1011011;
            4'h6: o_seg = 7'b1011111;
            4'h7: o_seg = 7'b1110000;
            4'h8: o_seg = 7'b1111111;
            4'h9: o_seg = 7'b1111011;
            4'hA: o_seg = 7'b1110111;
            4'hB: o_seg = 7'b0011111;
            4'hC: o_seg = 7'b1001110;
            4'hD: o_seg = 7'b0111101;
            4'hE: o_seg = 7'b1001111;
            4'hF: o_seg = 7'b1000111;
            default: o_seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Multiplexed four-digit hex display scanner with anti-ghost blanking, leading-zero
// suppression and tear-free value updates at frame boundaries.
module seg_display_scanner
    import seg_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_value,
    input  logic        i_load,
    input  logic        i_blank_lz,
    input  logic [3:0]  i_dp,
    output logic [6:0]  o_seg,
    output logic [3:0]  o_an,
    output logic        o_dp,
    output logic        o_frame
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);

    logic [CntW-1:0]       r_count, w_count_d;
    digit_idx_t            r_index, w_index_d;
    logic [15:0]           r_display, w_display_d;
    logic [15:0]           r_pending, w_pending_d;
    logic                  r_pend_vld, w_pend_vld_d;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an, w_an_d;
    logic                  r_dp, w_dp_d;
    logic                  r_frame;

    logic                  w_tick, w_wrap, w_an_off;
    logic [DIGIT_W-1:0]    w_nibble;
    logic [6:0]            w_seg;
    logic [NUM_DIGITS-1:0] w_lz_mask;

    assign w_tick    = (r_count == CntLast);
    assign w_wrap    = w_tick && (r_index == digit_idx_t'(NUM_DIGITS - 1));
    assign w_nibble  = r_display[r_index*DIGIT_W +: DIGIT_W];
    assign w_lz_mask = lz_blank_mask(r_display);

    hex_7seg_decoder u_decoder (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count    <= '0;
            r_index    <= '0;
            r_display  <= '0;
            r_pending  <= '0;
            r_pend_vld <= 1'b0;
            r_an       <= AN_OFF;
            r_seg      <= '0;
            r_dp       <= 1'b1;
            r_frame    <= 1'b0;
        end else begin
            r_count    <= w_count_d;
            r_index    <= w_index_d;
            r_display  <= w_display_d;
            r_pending  <= w_pending_d;
            r_pend_vld <= w_pend_vld_d;
            r_an       <= w_an_d;
            r_seg      <= w_seg;
            r_dp       <= w_dp_d;
            r_frame    <= w_wrap;
        end
    end

    // A load landing on the wrap tick bypasses the pending register entirely.
    always_comb begin
        w_count_d    = w_tick ? '0 : r_count + 1'b1;
        w_index_d    = w_tick ? r_index + 1'b1 : r_index;
        w_display_d  = r_display;
        w_pending_d  = r_pending;
        w_pend_vld_d = r_pend_vld;
        if (i_load && w_wrap) begin
            w_display_d  = i_value;
            w_pend_vld_d = 1'b0;
        end else if (i_load) begin
            w_pending_d  = i_value;
            w_pend_vld_d = 1'b1;
        end else if (w_wrap && r_pend_vld) begin
            w_display_d  = r_pending;
            w_pend_vld_d = 1'b0;
        end
    end

    always_comb begin
        w_an_off = (r_count < CntBlank) || (i_blank_lz && w_lz_mask[r_index]);
        w_an_d   = w_an_off ? AN_OFF : ~(NUM_DIGITS'(1) << r_index);
        w_dp_d   = w_an_off | ~i_dp[r_index];
    end

    assign o_seg   = r_seg;
    assign o_an    = r_an;
    assign o_dp    = r_dp;
    assign o_frame = r_frame;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Randomized self-checking bench for seg_display_scanner against a time-based display model.
module tb_seg_display_scanner;

    localparam int unsigned Div   = 4;
    localparam int unsigned Blank = 1;
    localparam int unsigned Frame = Div * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  dp = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp_n;
    logic        frame;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: cycles since reset release, shown value, pending value.
    int unsigned m_t = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    bit          m_pend_vld = 1'b0;

    logic [6:0] seg_lut [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    seg_display_scanner #(
        .REFRESH_DIV  (Div),
        .BLANK_CYCLES (Blank)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_value    (value),
        .i_load     (load),
        .i_blank_lz (blank_lz),
        .i_dp       (dp),
        .o_seg      (seg),
        .o_an       (an),
        .o_dp       (dp_n),
        .o_frame    (frame)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // One clock: drive inputs, predict outputs from the pre-edge model, advance model, compare.
    task automatic step(input bit ld, input logic [15:0] val, input bit bl, input logic [3:0] d);
        int unsigned phase, digit;
        logic [15:0] upper;
        logic [3:0]  nib, e_an;
        logic [6:0]  e_seg;
        bit          off, wrap, e_dp;
        @(negedge clk);
        load     = ld;
        value    = val;
        blank_lz = bl;
        dp       = d;
        phase = m_t % Div;
        digit = (m_t / Div) % 4;
        upper = m_disp >> (4 * digit);
        nib   = m_disp[4*digit +: 4];
        off   = (phase < Blank) || (bl && digit != 0 && upper == 16'h0);
        e_an  = off ? 4'hF : ~(4'b0001 << digit);
        e_seg = seg_lut[nib];
        e_dp  = off ? 1'b1 : ~d[digit];
        wrap  = (phase == Div - 1) && (digit == 3);
        if (ld && wrap) begin
            m_disp     = val;
            m_pend_vld = 1'b0;
        end else if (ld) begin
            m_pend     = val;
            m_pend_vld = 1'b1;
        end else if (wrap && m_pend_vld) begin
            m_disp     = m_pend;
            m_pend_vld = 1'b0;
        end
        m_t++;
        @(posedge clk);
        #1;
        check_val("an", 32'(an), 32'(e_an));
        check_val("seg", 32'(seg), 32'(e_seg));
        check_val("dp", 32'(dp_n), 32'(e_dp));
        check_val("frame", 32'(frame), 32'(wrap));
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        load  = 1'b0;
        #1;
        check_val("rst_an", 32'(an), 32'hF);
        check_val("rst_seg", 32'(seg), 32'h0);
        check_val("rst_dp", 32'(dp_n), 32'h1);
        check_val("rst_frame", 32'(frame), 32'h0);
        @(posedge clk);
        #2;
        rst_n      = 1'b1;
        m_t        = 0;
        m_disp     = '0;
        m_pend_vld = 1'b0;
    endtask

    task automatic idle(input int n, input bit bl, input logic [3:0] d);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, bl, d);
    endtask

    task automatic idle_to(input int unsigned pos, input bit bl, input logic [3:0] d);
        for (int i = 0; i < int'(Frame) && (m_t % Frame) != pos; i++) step(1'b0, 16'h0, bl, d);
    endtask

    function automatic logic [15:0] rand_value();
        logic [15:0] v;
        v = 16'($urandom);
        for (int k = 0; k < 4; k++) if ($urandom_range(1, 0) == 0) v[4*k +: 4] = 4'h0;
        return v;
    endfunction

    initial begin
        async_reset();

        step(1'b1, 16'h1234, 1'b0, 4'h0);
        idle(40, 1'b0, 4'h0);

        step(1'b1, 16'h0005, 1'b1, 4'h0);
        idle(40, 1'b1, 4'h0);
        step(1'b1, 16'h0000, 1'b1, 4'h0);
        idle(40, 1'b1, 4'h0);

        idle_to(5, 1'b0, 4'h0);
        step(1'b1, 16'hAAAA, 1'b0, 4'h0);
        idle(3, 1'b0, 4'h0);
        step(1'b1, 16'hBBBB, 1'b0, 4'h0);
        idle(40, 1'b0, 4'h0);

        idle_to(Frame - 1, 1'b0, 4'h0);
        step(1'b1, 16'hC0DE, 1'b0, 4'h0);
        idle(20, 1'b0, 4'h0);

        idle(20, 1'b0, 4'b0100);

        step(1'b1, 16'h9999, 1'b0, 4'h0);
        idle_to(2 * Div + 1, 1'b0, 4'h0);
        async_reset();
        idle(40, 1'b0, 4'h0);

        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(15, 0) == 0), rand_value(), 1'($urandom), 4'($urandom));
            if ($urandom_range(499, 0) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
